// File: rtl/matmul_unit.sv
// matmul_unit: N x N unsigned integer matrix multiply over the shared dmem port.
// Loads A then B element by element, computes one C element per cycle, then
// stores C. All arithmetic wraps modulo 2^32.
module matmul_unit #(
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_base,
  input  logic [31:0] b_base,
  input  logic [31:0] c_base,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int NN = N * N;
  localparam int IW = $clog2(NN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMP, STORE} stateT;

  stateT         stateReg, stateNext;
  logic [IW-1:0] idxReg, idxNext;
  logic [31:0]   aBaseReg, bBaseReg, cBaseReg;
  logic          busyReg, doneReg;
  logic          lastIdx;

  logic [31:0]   matA [NN];
  logic [31:0]   matB [NN];
  logic [31:0]   matC [NN];

  int            compRow, compCol;
  logic [31:0]   prodTerm [N];
  logic [31:0]   dotSum;
  logic [31:0]   byteOff;

  assign lastIdx = (idxReg == LAST_IDX);
  assign busy    = busyReg;
  assign done    = doneReg;

  // Control registers: state, index, latched bases, registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      idxReg   <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      aBaseReg <= '0;
      bBaseReg <= '0;
      cBaseReg <= '0;
    end else begin
      stateReg <= stateNext;
      idxReg   <= idxNext;
      busyReg  <= (stateNext != IDLE);
      doneReg  <= (stateReg == STORE) && lastIdx;
      // Bases are only captured on an accepted start; later strobes are ignored.
      if (stateReg == IDLE && start) begin
        aBaseReg <= a_base;
        bBaseReg <= b_base;
        cBaseReg <= c_base;
      end
    end
  end

  // Next-state and element-index sequencing; each phase walks idx 0..N*N-1.
  always_comb begin
    stateNext = stateReg;
    idxNext   = idxReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = LOAD_A;
          idxNext   = '0;
        end
      end
      LOAD_A: begin
        if (lastIdx) begin
          stateNext = LOAD_B;
          idxNext   = '0;
        end else begin
          idxNext = idxReg + 1'b1;
        end
      end
      LOAD_B: begin
        if (lastIdx) begin
          stateNext = COMP;
          idxNext   = '0;
        end else begin
          idxNext = idxReg + 1'b1;
        end
      end
      COMP: begin
        if (lastIdx) begin
          stateNext = STORE;
          idxNext   = '0;
        end else begin
          idxNext = idxReg + 1'b1;
        end
      end
      STORE: begin
        if (lastIdx) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else begin
          idxNext = idxReg + 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
    endcase
  end

  // Row/column of the C element being computed this cycle.
  assign compRow = int'(idxReg) / N;
  assign compCol = int'(idxReg) % N;

  // One low-32-bit product per inner-dimension term: A[row][k] * B[k][col].
  for (genvar gi = 0; gi < N; gi++) begin : gProd
    logic [IW-1:0] aSel, bSel;
    assign aSel         = IW'(compRow * N + gi);
    assign bSel         = IW'(gi * N + compCol);
    assign prodTerm[gi] = matA[aSel] * matB[bSel];
  end

  // Wrapping sum of the product terms.
  always_comb begin
    dotSum = '0;
    for (int k = 0; k < N; k++) begin
      dotSum = dotSum + prodTerm[k];
    end
  end

  // Matrix storage: no reset needed, every entry is written before it is read.
  always_ff @(posedge clk) begin
    case (stateReg)
      LOAD_A:  matA[idxReg] <= mem_rdata;
      LOAD_B:  matB[idxReg] <= mem_rdata;
      COMP:    matC[idxReg] <= dotSum;
      default: ;
    endcase
  end

  // Memory port decoded purely from registered state and index.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    byteOff   = 32'(idxReg) << 2;
    case (stateReg)
      LOAD_A: mem_addr = aBaseReg + byteOff;
      LOAD_B: mem_addr = bBaseReg + byteOff;
      STORE: begin
        mem_addr  = cBaseReg + byteOff;
        mem_wdata = matC[idxReg];
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_unit.sv
// Testbench for matmul_unit (N=2): sparse memory model, write/read logging,
// and a plain nested-loop reference product.
module tb_matmul_unit;

  localparam int N  = 2;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] aBase = '0, bBase = '0, cBase = '0;
  logic        busy, done, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [logic [31:0]];
  int          memVer = 0;
  logic [31:0] wrAddr [$];
  logic [31:0] wrData [$];
  logic [31:0] rdAddr [$];
  int          weOutside = 0;

  int checks = 0;
  int failures = 0;

  matmul_unit #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_base   (aBase),
    .b_base   (bBase),
    .c_base   (cBase),
    .busy     (busy),
    .done     (done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Combinational read port of the memory model.
  always @(mem_addr or memVer) begin
    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0BAD_0BAD;
  end

  // Log every write, and the address of every non-write busy cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
      if (!busy) weOutside <= weOutside + 1;
    end else if (busy) begin
      rdAddr.push_back(mem_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic loadMat(input logic [31:0] base, input logic [31:0] v [NN]);
    for (int i = 0; i < NN; i++) mem[base + 32'(4 * i)] = v[i];
    memVer++;
  endtask

  function automatic void refMul(input logic [31:0] a [NN], input logic [31:0] b [NN],
                                 output logic [31:0] c [NN]);
    for (int r = 0; r < N; r++) begin
      for (int cc = 0; cc < N; cc++) begin
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < N; k++) s = s + a[r * N + k] * b[k * N + cc];
        c[r * N + cc] = s;
      end
    end
  endfunction

  // Start one run; optionally inject a second start strobe at cycle intrAt.
  task automatic doRun(input logic [31:0] ab, input logic [31:0] bb, input logic [31:0] cb,
                       input int intrAt, output int busyCnt, output int doneAt,
                       output int wrStart, output int rdStart);
    busyCnt = 0;
    doneAt  = -1;
    @(negedge clk);
    wrStart = wrAddr.size();
    rdStart = rdAddr.size();
    aBase = ab; bBase = bb; cBase = cb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneAt = t;
        break;
      end
      if (t == intrAt) begin
        aBase = ab + 32'h40; bBase = bb + 32'h40; cBase = cb + 32'h1000; start = 1'b1;
      end else if (t == intrAt + 1) begin
        aBase = ab; bBase = bb; cBase = cb; start = 1'b0;
      end
    end
    start = 1'b0;
    $display("run a=%08h b=%08h c=%08h busy_cycles=%0d done_at=%0d", ab, bb, cb, busyCnt, doneAt);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%08h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%08h exp=0", mem_wdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] a [NN] = '{1, 2, 3, 4};
    logic [31:0] b [NN] = '{5, 6, 7, 8};
    logic [31:0] req [NN] = '{19, 22, 43, 50};
    int bc, da, ws, rs;
    loadMat(32'h100, a);
    loadMat(32'h200, b);
    doRun(32'h100, 32'h200, 32'h300, -1, bc, da, ws, rs);
    checks++; if (bc != 16) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=16", bc); end
    checks++; if (da != 17) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=17", da); end
    checks++;
    if (wrAddr.size() - ws != NN) begin
      failures++; $display("FAIL basic_write_count got=%0d exp=%0d", wrAddr.size() - ws, NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (wrAddr[ws + i] !== 32'h300 + 32'(4 * i) || wrData[ws + i] !== req[i]) begin
          failures++;
          $display("FAIL basic_C%0d got=%08h@%08h exp=%08h@%08h", i, wrData[ws + i], wrAddr[ws + i],
                   req[i], 32'h300 + 32'(4 * i));
        end
      end
    end
  endtask

  // Product runs: two fixed overflow cases followed by random matrices.
  task automatic test_products;
    logic [31:0] a [NN];
    logic [31:0] b [NN];
    logic [31:0] req [NN];
    logic [31:0] ab, bb, cb;
    int bc, da, ws, rs;
    for (int run = 0; run < 5; run++) begin
      for (int i = 0; i < NN; i++) begin
        case (run)
          0: begin a[i] = 32'h0001_0000; b[i] = 32'h0001_0000; end
          1: begin a[i] = 32'hFFFF_FFFF; b[i] = (i % (N + 1) == 0) ? 32'd1 : 32'd0; end
          default: begin a[i] = $urandom; b[i] = $urandom; end
        endcase
      end
      refMul(a, b, req);
      if (run == 0) for (int i = 0; i < NN; i++) begin
        checks++; if (req[i] !== 32'h0) begin failures++; $display("FAIL overflow_model got=%08h exp=0", req[i]); end
      end
      ab = 32'h1000 + 32'($urandom_range(0, 15)) * 32'h40;
      bb = 32'h2000 + 32'($urandom_range(0, 15)) * 32'h40;
      cb = 32'h3000 + 32'($urandom_range(0, 15)) * 32'h40;
      loadMat(ab, a);
      loadMat(bb, b);
      doRun(ab, bb, cb, -1, bc, da, ws, rs);
      checks++; if (da != 4 * NN + 1) begin failures++; $display("FAIL prod%0d_done_cycle got=%0d exp=%0d", run, da, 4 * NN + 1); end
      checks++;
      if (wrAddr.size() - ws != NN) begin
        failures++; $display("FAIL prod%0d_write_count got=%0d exp=%0d", run, wrAddr.size() - ws, NN);
      end else begin
        for (int i = 0; i < NN; i++) begin
          checks++;
          if (wrAddr[ws + i] !== cb + 32'(4 * i) || wrData[ws + i] !== req[i]) begin
            failures++;
            $display("FAIL prod%0d_C%0d got=%08h@%08h exp=%08h@%08h", run, i, wrData[ws + i],
                     wrAddr[ws + i], req[i], cb + 32'(4 * i));
          end
        end
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic [31:0] a [NN];
    logic [31:0] b [NN];
    logic [31:0] req [NN];
    int bc, da, ws, rs;
    for (int i = 0; i < NN; i++) begin a[i] = $urandom; b[i] = $urandom; end
    refMul(a, b, req);
    loadMat(32'h4000, a);
    loadMat(32'h5000, b);
    // Decoy matrices behind the bases of the ignored strobe.
    for (int i = 0; i < NN; i++) begin a[i] = $urandom; b[i] = $urandom; end
    loadMat(32'h4040, a);
    loadMat(32'h5040, b);
    doRun(32'h4000, 32'h5000, 32'h6000, 5, bc, da, ws, rs);
    checks++; if (da != 17) begin failures++; $display("FAIL swb_done_cycle got=%0d exp=17", da); end
    checks++; if (bc != 16) begin failures++; $display("FAIL swb_busy_cycles got=%0d exp=16", bc); end
    checks++;
    if (wrAddr.size() - ws != NN) begin
      failures++; $display("FAIL swb_write_count got=%0d exp=%0d", wrAddr.size() - ws, NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (wrAddr[ws + i] !== 32'h6000 + 32'(4 * i) || wrData[ws + i] !== req[i]) begin
          failures++;
          $display("FAIL swb_C%0d got=%08h@%08h exp=%08h@%08h", i, wrData[ws + i], wrAddr[ws + i],
                   req[i], 32'h6000 + 32'(4 * i));
        end
      end
    end
    // No restart may follow the first run.
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL swb_no_restart got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a [NN];
    logic [31:0] b [NN];
    logic [31:0] req [NN];
    int bc, da, ws, rs;
    for (int i = 0; i < NN; i++) begin a[i] = $urandom; b[i] = $urandom; end
    refMul(a, b, req);
    loadMat(32'h7000, a);
    loadMat(32'h7100, b);
    @(negedge clk);
    ws = wrAddr.size();
    aBase = 32'h7000; bBase = 32'h7100; cBase = 32'h7200; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);   // cycle 6 lies in LOAD_B
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmid_we_async got=%b exp=0", mem_we); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rmid_we got=%b exp=0", mem_we); end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wrAddr.size() != ws) begin failures++; $display("FAIL rmid_no_writes got=%0d exp=0", wrAddr.size() - ws); end
    $display("run a=00007000 b=00007100 c=00007200 aborted_by_reset");
    doRun(32'h7000, 32'h7100, 32'h7200, -1, bc, da, ws, rs);
    checks++; if (da != 17) begin failures++; $display("FAIL rmid_fresh_done got=%0d exp=17", da); end
    checks++;
    if (wrAddr.size() - ws != NN) begin
      failures++; $display("FAIL rmid_fresh_count got=%0d exp=%0d", wrAddr.size() - ws, NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (wrAddr[ws + i] !== 32'h7200 + 32'(4 * i) || wrData[ws + i] !== req[i]) begin
          failures++;
          $display("FAIL rmid_fresh_C%0d got=%08h exp=%08h", i, wrData[ws + i], req[i]);
        end
      end
    end
  endtask

  task automatic test_addr_wrap;
    logic [31:0] a [NN];
    logic [31:0] b [NN];
    logic [31:0] req [NN];
    logic [31:0] expAddr [NN] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int bc, da, ws, rs;
    for (int i = 0; i < NN; i++) begin a[i] = $urandom; b[i] = $urandom; end
    refMul(a, b, req);
    loadMat(32'hFFFF_FFF8, a);
    loadMat(32'h8000, b);
    doRun(32'hFFFF_FFF8, 32'h8000, 32'h8100, -1, bc, da, ws, rs);
    checks++;
    if (rdAddr.size() - rs < NN) begin
      failures++; $display("FAIL wrap_read_count got=%0d exp>=%0d", rdAddr.size() - rs, NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (rdAddr[rs + i] !== expAddr[i]) begin
          failures++; $display("FAIL wrap_read%0d got=%08h exp=%08h", i, rdAddr[rs + i], expAddr[i]);
        end
      end
    end
    checks++;
    if (wrAddr.size() - ws != NN) begin
      failures++; $display("FAIL wrap_write_count got=%0d exp=%0d", wrAddr.size() - ws, NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (wrData[ws + i] !== req[i]) begin
          failures++; $display("FAIL wrap_C%0d got=%08h exp=%08h", i, wrData[ws + i], req[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1 [NN];
    logic [31:0] b1 [NN];
    logic [31:0] a2 [NN];
    logic [31:0] b2 [NN];
    logic [31:0] r1 [NN];
    logic [31:0] r2 [NN];
    int bc, d1, d2, ws;
    for (int i = 0; i < NN; i++) begin
      a1[i] = $urandom; b1[i] = $urandom; a2[i] = $urandom; b2[i] = $urandom;
    end
    refMul(a1, b1, r1);
    refMul(a2, b2, r2);
    loadMat(32'h9000, a1); loadMat(32'h9100, b1);
    loadMat(32'h9200, a2); loadMat(32'h9300, b2);
    bc = 0; d1 = -1; d2 = -1;
    @(negedge clk);
    ws = wrAddr.size();
    aBase = 32'h9000; bBase = 32'h9100; cBase = 32'h9400; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        if (d1 < 0) begin
          d1 = t;
          aBase = 32'h9200; bBase = 32'h9300; cBase = 32'h9500; start = 1'b1;
        end else begin
          d2 = t;
          break;
        end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("run back_to_back done1_at=%0d done2_at=%0d busy_cycles=%0d", d1, d2, bc);
    checks++; if (d1 != 17) begin failures++; $display("FAIL b2b_done1 got=%0d exp=17", d1); end
    checks++; if (d2 != 34) begin failures++; $display("FAIL b2b_done2 got=%0d exp=34", d2); end
    checks++; if (bc != 32) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=32", bc); end
    checks++;
    if (wrAddr.size() - ws != 2 * NN) begin
      failures++; $display("FAIL b2b_write_count got=%0d exp=%0d", wrAddr.size() - ws, 2 * NN);
    end else begin
      for (int i = 0; i < NN; i++) begin
        checks++;
        if (wrAddr[ws + i] !== 32'h9400 + 32'(4 * i) || wrData[ws + i] !== r1[i]) begin
          failures++; $display("FAIL b2b_first_C%0d got=%08h exp=%08h", i, wrData[ws + i], r1[i]);
        end
        checks++;
        if (wrAddr[ws + NN + i] !== 32'h9500 + 32'(4 * i) || wrData[ws + NN + i] !== r2[i]) begin
          failures++; $display("FAIL b2b_second_C%0d got=%08h exp=%08h", i, wrData[ws + NN + i], r2[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products();
    test_start_while_busy();
    test_reset_mid();
    test_addr_wrap();
    test_back_to_back();
    checks++;
    if (weOutside != 0) begin failures++; $display("FAIL we_outside_busy got=%0d exp=0", weOutside); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_unit.md
# matmul_unit

Fixed-size integer matrix-multiply engine attached to the pipeline's Execute stage. It accepts a one-cycle start strobe carrying three base addresses, takes over the data-memory port while busy, and reads two N×N row-major 32-bit matrices A and B. It computes C = A·B with modulo-2^32 arithmetic and writes C back to memory. The core holds Fetch/Decode while `busy` is high and muxes `mem_we` onto the dmem write enable.

## Interface
- `N`, 2: matrix dimension; legal range 2..4.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle start strobe from Execute, already qualified against Memory-stage stores.
- `a_base`  in  32  byte address of A[0][0].
- `b_base`  in  32  byte address of B[0][0].
- `c_base`  in  32  byte address of C[0][0].
- `busy`  out  1  engine owns the dmem port.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  32  dmem byte address.
- `mem_wdata`  out  32  dmem write data.
- `mem_we`  out  1  dmem write enable.
- `mem_rdata`  in  32  dmem read data; combinational, valid in the same cycle as `mem_addr`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, COMP, STORE.
- Element index `idx` runs 0..N²−1. Element (r,c) sits at `idx` = r·N+c, address base + 4·idx, wrapping modulo 2^32.
- IDLE:
  - `start`=1 latches all three bases, clears `idx`, and moves to LOAD_A.
  - `start` in any other state is ignored: no relatch, no restart.
- LOAD_A: drive `mem_addr` = a_base+4·idx and capture `mem_rdata` into A[idx] at the clock edge.
  - At idx = N²−1, clear idx and go to LOAD_B.
- LOAD_B: same as LOAD_A, using b_base and B[idx]. At the last element, go to COMP.
- COMP: compute one C element per cycle, C[idx] = Σₖ A[r][k]·B[k][c] for k = 0..N−1.
  - Only the low 32 bits of each product and of the sum are kept; operands are treated as unsigned.
  - At the last element, go to STORE.
- STORE: drive `mem_addr` = c_base+4·idx, `mem_wdata` = C[idx], `mem_we` = 1.
  - At the last element, go to IDLE and pulse `done` for one cycle.
- Outside the load/store states: `mem_addr` = 0, `mem_wdata` = 0, `mem_we` = 0.
- `mem_we` is never high outside STORE.
- Overlapping regions (e.g. c_base = a_base) are legal. All loads finish before any store, so results use the original A and B values.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - State = IDLE, idx = 0.
  - Matrix storage need not be cleared.
- Reset asserted mid-operation returns the engine to IDLE immediately; `mem_we` drops asynchronously. Writes already completed stay in memory; no further writes occur.
- Cycle 0 is the edge that samples `start`.
- `busy` is registered. It is high from cycle 0+ (the cycle after the start edge) through the last STORE cycle, which is 4·N² cycles in total.
- `done` is high during the single cycle following the last STORE cycle. `busy` is 0 in that cycle, and a new `start` is accepted then.
- Memory outputs (`mem_addr`, `mem_wdata`, `mem_we`) are decoded from registered state and index only, so they are glitch-free relative to `start`.
- Total latency from start to done: 4·N²+1 cycles (N=2: 17; N=4: 65).

## Test plan
- Basic product, N=2:
  - Memory: A=[1,2,3,4] at 0x100, B=[5,6,7,8] at 0x200; c_base=0x300.
  - Required: words at 0x300..0x30C = 19, 22, 43, 50.
  - Required: `busy` high for exactly 16 cycles, `done` at cycle 17, exactly 4 writes seen.
- Overflow, N=2: A all 0x00010000, B all 0x00010000 → C all 0x00000000. With A all 0xFFFFFFFF and B = identity → C = A.
- Start while busy: pulse `start` with different bases at cycle 5 of a run → ignored; results and write addresses match the first request only.
- Reset mid-run: drop `reset` during LOAD_B → next cycle `busy`=0 and `mem_we`=0, with no writes afterwards. A fresh start then completes correctly.
- Address wrap, N=2: a_base=0xFFFFFFF8 → reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Back-to-back runs: start asserted in the `done` cycle is accepted; the second result is correct and `busy` has no gap beyond that single cycle.
